// File: rtl/pausable_counter_pkg.sv
// Shared types and default parameters for the pausable counter slice.
package pausable_counter_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_e;

  localparam int unsigned WIDTH_DEF          = 4;
  localparam int unsigned DEBOUNCE_WIDTH_DEF = 16;
  // 5 ms at 12 MHz, minus one
  localparam int unsigned DEBOUNCE_COUNT_DEF = 60000 - 1;

endpackage

// File: rtl/pausable_counter_if.sv
// Control and status signals of the pausable counter.
interface pausable_counter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             tick;
  logic             btn_pause;
  logic [WIDTH-1:0] count;
  logic             paused;
  logic             wrap;

  modport master (
    output tick,
    output btn_pause,
    input  count,
    input  paused,
    input  wrap
  );

  modport slave (
    input  tick,
    input  btn_pause,
    output count,
    output paused,
    output wrap
  );

endinterface

// File: rtl/pausable_counter_button_debouncer.sv
// Two-flop synchronizer, counting debouncer and press (0->1) detector for a raw pushbutton.
module button_debouncer
  import pausable_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEF,
  parameter int unsigned DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press
);

  logic                      sync_q1;
  logic                      sync_q2;
  logic [DEBOUNCE_WIDTH-1:0] db_cnt;

  // press is registered alongside level so it pulses in the first cycle level reads 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      db_cnt  <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DEBOUNCE_WIDTH'(DEBOUNCE_COUNT)) begin
        level  <= sync_q2;
        press  <= sync_q2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DEBOUNCE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pausable_counter.sv
// Free-running counter advanced by tick, paused and resumed by a debounced pushbutton.
module pausable_counter
  import pausable_counter_pkg::*;
#(
  parameter int unsigned WIDTH          = WIDTH_DEF,
  parameter int unsigned DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEF,
  parameter int unsigned DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  pausable_counter_if.slave   bus
);

  logic             btn_level;
  logic             btn_press;
  logic             press_c;
  logic             inc_c;
  state_e           state_q;
  state_e           state_nxt;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             paused_q;

  button_debouncer #(
    .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH),
    .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
  ) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .btn_in (bus.btn_pause),
    .level  (btn_level),
    .press  (btn_press)
  );

  // a press is only valid while the accepted button level is high
  assign press_c = btn_press & btn_level;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (press_c) begin
      case (state_q)
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // tick is qualified by the state before any transition this cycle
  always_comb begin
    inc_c = 1'b0;
    if (state_q == RUN) inc_c = bus.tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wrap_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      wrap_q   <= inc_c & (count_q == '1);
      paused_q <= (state_nxt == PAUSE);
      if (inc_c) count_q <= count_q + WIDTH'(1);
    end
  end

  assign bus.count  = count_q;
  assign bus.wrap   = wrap_q;
  assign bus.paused = paused_q;

endmodule

// File: tb/tb_pausable_counter.sv
// Directed bench for pausable_counter with WIDTH=4 and DEBOUNCE_COUNT=3.
module tb_pausable_counter;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pausable_counter_if #(.WIDTH(W)) bus ();

  pausable_counter #(
    .WIDTH          (W),
    .DEBOUNCE_WIDTH (4),
    .DEBOUNCE_COUNT (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   wraps;
  int   toggles;
  int   wrap_count_val;
  logic last_paused;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // advance one rising edge, then settle
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.wrap === 1'b1) begin
      wraps++;
      wrap_count_val = int'(bus.count);
    end
    if (bus.paused !== last_paused) toggles++;
    last_paused = bus.paused;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
    end
  endtask

  task automatic press_release();
    bus.btn_pause = 1'b1;
    steps(10);
    bus.btn_pause = 1'b0;
    steps(10);
  endtask

  initial begin
    rst           = 1'b1;
    bus.tick      = 1'b0;
    bus.btn_pause = 1'b0;
    wraps         = 0;
    toggles       = 0;
    wrap_count_val = -1;
    last_paused   = 1'b0;
    step();
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_paused", 32'(bus.paused), 32'd0);
    check("reset_wrap", 32'(bus.wrap), 32'd0);
    rst = 1'b0;

    // 20 single-cycle ticks, then a back-to-back burst of 3
    wraps = 0;
    run_ticks(20);
    check("ticks20_count", 32'(bus.count), 32'd4);
    check("ticks20_wraps", 32'(wraps), 32'd1);
    check("ticks20_wrap_at_zero", 32'(wrap_count_val), 32'd0);
    check("ticks20_paused", 32'(bus.paused), 32'd0);
    bus.tick = 1'b1;
    steps(3);
    bus.tick = 1'b0;
    step();
    check("burst_count", 32'(bus.count), 32'd7);

    // press timing: paused flips on the 7th sampling edge
    bus.btn_pause = 1'b1;
    steps(6);
    check("press_edge6_paused", 32'(bus.paused), 32'd0);
    step();
    check("press_edge7_paused", 32'(bus.paused), 32'd1);
    wraps = 0;
    run_ticks(5);
    check("paused_ticks_count", 32'(bus.count), 32'd7);
    check("paused_ticks_wraps", 32'(wraps), 32'd0);
    bus.btn_pause = 1'b0;
    steps(10);
    check("release_no_event", 32'(bus.paused), 32'd1);

    // short glitch, then two full press/release cycles
    bus.btn_pause = 1'b1;
    steps(3);
    bus.btn_pause = 1'b0;
    steps(10);
    check("glitch_paused", 32'(bus.paused), 32'd1);
    toggles = 0;
    press_release();
    press_release();
    check("two_press_toggles", 32'(toggles), 32'd2);
    check("two_press_paused", 32'(bus.paused), 32'd1);

    // tick coincident with press, from RUN at count 15
    press_release();
    check("resume_paused", 32'(bus.paused), 32'd0);
    run_ticks(8);
    check("pre_wrap_count", 32'(bus.count), 32'd15);
    bus.btn_pause = 1'b1;
    steps(6);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check("run_tick_press_count", 32'(bus.count), 32'd0);
    check("run_tick_press_wrap", 32'(bus.wrap), 32'd1);
    check("run_tick_press_paused", 32'(bus.paused), 32'd1);
    step();
    check("wrap_one_cycle", 32'(bus.wrap), 32'd0);
    bus.btn_pause = 1'b0;
    steps(10);

    // tick coincident with press, from PAUSE
    bus.btn_pause = 1'b1;
    steps(6);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check("pause_tick_press_count", 32'(bus.count), 32'd0);
    check("pause_tick_press_wrap", 32'(bus.wrap), 32'd0);
    check("pause_tick_press_paused", 32'(bus.paused), 32'd0);
    bus.btn_pause = 1'b0;
    steps(10);

    // reset mid-debounce while paused at count 9
    run_ticks(9);
    press_release();
    check("pre_rst_count", 32'(bus.count), 32'd9);
    check("pre_rst_paused", 32'(bus.paused), 32'd1);
    bus.btn_pause = 1'b1;
    steps(4);
    rst      = 1'b1;
    bus.tick = 1'b1;
    step();
    rst      = 1'b0;
    bus.tick = 1'b0;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_paused", 32'(bus.paused), 32'd0);
    check("rst_wrap", 32'(bus.wrap), 32'd0);
    steps(6);
    check("post_rst_edge6_paused", 32'(bus.paused), 32'd0);
    step();
    check("post_rst_edge7_paused", 32'(bus.paused), 32'd1);
    bus.btn_pause = 1'b0;
    steps(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pausable_counter.md
PAUSABLE_COUNTER -- requirements
Module: pausable_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have parameter DEBOUNCE_WIDTH, default 16, giving the debounce counter width in bits.
REQ-003 The block SHALL have parameter DEBOUNCE_COUNT, default 60000-1 (5 ms at 12 MHz), giving the stable-cycle threshold minus one.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port tick, input, 1 bit: enable pulse from the upstream clock divider, synchronous to clk.
REQ-007 The block SHALL have port btn_pause, input, 1 bit: raw asynchronous pushbutton, active-high.
REQ-008 The block SHALL have port count, output, WIDTH bits: registered counter value.
REQ-009 The block SHALL have port paused, output, 1 bit: registered; 1 while in PAUSE.
REQ-010 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse on counter rollover.

Function
REQ-011 btn_pause SHALL pass through a two-flop synchronizer before any other use.
REQ-012 The debouncer SHALL hold accepted level db; its counter SHALL clear whenever the synchronized input equals db.
REQ-013 When the input differs from db, the counter SHALL increment each clock. On the clock where it equals DEBOUNCE_COUNT, db SHALL take the input value and the counter SHALL clear.
REQ-014 A press event SHALL be a single-cycle pulse on db rising 0->1. Releases SHALL generate no event.
REQ-015 The FSM SHALL have exactly two states, RUN and PAUSE. A press in RUN SHALL go to PAUSE; a press in PAUSE SHALL go to RUN; otherwise the state SHALL hold.
REQ-016 paused SHALL change on the (DEBOUNCE_COUNT+4)th rising edge at which btn_pause is sampled continuously high, counting the first sampling edge as the 1st.
REQ-017 In RUN with tick=1, count SHALL become (count+1) mod 2^WIDTH on that edge.
REQ-018 In PAUSE, tick SHALL be ignored; count and wrap SHALL hold/stay 0.
REQ-019 wrap SHALL be 1 for exactly the cycle after count goes from 2^WIDTH-1 to 0, and 0 otherwise.
REQ-020 When tick is high on consecutive cycles in RUN, each cycle SHALL increment the count; the block SHALL not assume a pulse shape.
REQ-021 On simultaneous tick and press, the tick SHALL be qualified by the pre-transition state. RUN: increment, then PAUSE. PAUSE: no increment, then RUN.
REQ-022 Glitches on btn_pause shorter than DEBOUNCE_COUNT+1 synchronized cycles SHALL produce no event.
REQ-023 Holding the button SHALL produce one event only; the next event SHALL require a debounced release, then a press.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL set: count=0, wrap=0, paused=0, state=RUN, db=0, debounce counter=0, synchronizer flops=0.
REQ-025 rst SHALL take priority over tick and press in the same cycle.
REQ-026 A debounce in progress when rst asserts SHALL be discarded.
REQ-027 After rst deasserts, a button still held high SHALL register as a new press after full debounce.

Structure
REQ-028 The shared package SHALL hold the state encoding constants RUN=1'b0 and PAUSE=1'b1, and the default DEBOUNCE_COUNT.
REQ-029 Synchronizer plus debouncer plus rising-edge detector SHALL form one sub-module, button_debouncer, with ports clk, rst, btn_in, level, press.
REQ-030 Counter and FSM SHALL reside in pausable_counter.

Verification (WIDTH=4, DEBOUNCE_COUNT=3)
REQ-031 Bench SHALL cover: rst, then 20 single-cycle ticks, no button -> count=4 (20 mod 16), wrap pulsed once one cycle after count 15->0, paused=0.
REQ-032 Bench SHALL cover: btn_pause high from edge 1 -> paused=1 at edge 7; 5 subsequent ticks leave count unchanged, wrap=0.
REQ-033 Bench SHALL cover: btn_pause 3-cycle glitch -> paused unchanged; held 10 cycles, released, held again 10 cycles -> paused toggles twice total.
REQ-034 Bench SHALL cover: count=15 in RUN, tick coincident with press cycle -> count=0, wrap=1 next cycle, paused=1. Repeat in PAUSE with tick+press -> count held, paused=0.
REQ-035 Bench SHALL cover: rst asserted mid-debounce (counter=2) and while count=9, PAUSE -> next cycle count=0, paused=0, wrap=0. Button still held -> paused=1 after 7 more edges.
